// File: rtl/priv_ext_int_ctrl.sv
// priv_ext_int_ctrl: level/edge interrupt gateways, per-hart priority
// arbitration and claim/complete handshake for external interrupts.
module priv_ext_int_ctrl #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned PRIO_W = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK = '0,
  localparam int unsigned ID_W = $clog2(NUM_SRC+1)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NUM_SRC-1:0]        src_irq,
  input  logic                      cfg_wen,
  input  logic [7:0]                cfg_addr,
  input  logic [31:0]               cfg_wdata,
  output logic [31:0]               cfg_rdata,
  input  logic [NUM_HARTS-1:0]      claim_valid,
  output logic [NUM_HARTS*ID_W-1:0] claim_id,
  input  logic [NUM_HARTS-1:0]      complete_valid,
  input  logic [NUM_HARTS*ID_W-1:0] complete_id,
  output logic [NUM_HARTS-1:0]      ext_int
);

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] flight_q, flight_d;
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] set_w, clr_w, cmpl_w;

  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic [PRIO_W-1:0]  prio_d [NUM_SRC];
  logic [NUM_SRC-1:0] en_q   [NUM_HARTS];
  logic [NUM_SRC-1:0] en_d   [NUM_HARTS];
  logic [PRIO_W-1:0]  thr_q  [NUM_HARTS];
  logic [PRIO_W-1:0]  thr_d  [NUM_HARTS];
  logic [ID_W-1:0]    best_q [NUM_HARTS];
  logic [ID_W-1:0]    best_d [NUM_HARTS];

  logic cfg_unused;
  assign cfg_unused = ^cfg_wdata;

  // A stale best_q is masked once its pending bit has been cleared
  always_comb begin
    ext_int = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (best_q[h] == ID_W'(i+1) && pend_q[i]) ext_int[h] = 1'b1;
      end
    end
  end

  // Lower hart index wins when several harts claim the same ID
  always_comb begin
    claim_id = '0;
    clr_w = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ext_int[h] && best_q[h] == ID_W'(i+1) &&
            !(claim_valid[h] && clr_w[i])) begin
          claim_id[h*ID_W +: ID_W] = best_q[h];
          if (claim_valid[h]) clr_w[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    cmpl_w = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (complete_valid[h] && en_q[h][i] &&
            complete_id[h*ID_W +: ID_W] == ID_W'(i+1)) cmpl_w[i] = 1'b1;
      end
    end
  end

  always_comb begin
    set_w = ~flight_q & ((src_irq & ~EDGE_MASK) |
                         (src_irq & ~prev_q & EDGE_MASK));
    pend_d = (pend_q & ~clr_w) | set_w;
    flight_d = (flight_q & ~cmpl_w) | set_w;
  end

  // Strict compare keeps the lowest ID on priority ties
  always_comb begin
    logic [PRIO_W-1:0] bp;
    bp = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      best_d[h] = '0;
      bp = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pend_q[i] && en_q[h][i] && prio_q[i] > thr_q[h] &&
            prio_q[i] > bp) begin
          bp = prio_q[i];
          best_d[h] = ID_W'(i+1);
        end
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    en_d = en_q;
    thr_d = thr_q;
    if (cfg_wen) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_addr == 8'(i)) prio_d[i] = cfg_wdata[PRIO_W-1:0];
      end
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (cfg_addr == 8'(8'h40 + h)) en_d[h] = cfg_wdata[NUM_SRC:1];
        if (cfg_addr == 8'(8'h50 + h)) thr_d[h] = cfg_wdata[PRIO_W-1:0];
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cfg_addr == 8'(i)) cfg_rdata = 32'(prio_q[i]);
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (cfg_addr == 8'(8'h40 + h)) cfg_rdata = 32'({en_q[h], 1'b0});
      if (cfg_addr == 8'(8'h50 + h)) cfg_rdata = 32'(thr_q[h]);
    end
    if (cfg_addr == 8'h60) cfg_rdata = 32'({pend_q, 1'b0});
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q <= '0;
      flight_q <= '0;
      prev_q <= '0;
      prio_q <= '{default: '0};
      en_q <= '{default: '0};
      thr_q <= '{default: '0};
      best_q <= '{default: '0};
    end else begin
      pend_q <= pend_d;
      flight_q <= flight_d;
      prev_q <= src_irq;
      prio_q <= prio_d;
      en_q <= en_d;
      thr_q <= thr_d;
      best_q <= best_d;
    end
  end

endmodule
